// File: rtl/pp_reduce_if.sv
// Operand/result bundle for the partial-product reduction pipe.
// Both sides use valid/ready: a beat moves on a rising edge where valid and ready are both high.
interface pp_reduce_if #(
    parameter int N_PP  = 17,
    parameter int PP_W  = 68,
    parameter int OUT_W = 64,
    parameter int TAG_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N_PP*PP_W-1:0]   pp_flat;
    logic [PP_W-1:0]        sign_comp;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_sum;
    logic [TAG_W-1:0]       out_tag;

    modport master (
        output in_valid, pp_flat, sign_comp, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_tag
    );

    modport slave (
        input  in_valid, pp_flat, sign_comp, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_tag
    );
endinterface

// File: rtl/pp_reduce_pipe.sv
// Pipelined carry-save reduction of N_PP partial products plus a sign-compensation word.
// CSA levels are spread over stages 1..PIPE_DEPTH-1; the final stage holds the CPA result.
module pp_reduce_pipe #(
    parameter int N_PP       = 17,
    parameter int PP_W       = 68,
    parameter int OUT_W      = 64,
    parameter int PIPE_DEPTH = 3,
    parameter int TAG_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    pp_reduce_if.slave  bus
);
    localparam int N_OP  = N_PP + 1;
    localparam int IDX_W = $clog2(N_OP);

    typedef logic [N_OP-1:0][PP_W-1:0] ops_t;

    // Operand count after one 3:2 level; counts of 2 or less are final.
    function automatic int next_cnt(input int n);
        return (n > 2) ? (n / 3) * 2 + (n % 3) : n;
    endfunction

    function automatic int count_levels(input int n);
        int m;
        int c;
        m = n;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (m > 2) begin
                m = next_cnt(m);
                c++;
            end
        end
        return c;
    endfunction

    localparam int N_LVL    = count_levels(N_OP);
    localparam int N_CSA_ST = PIPE_DEPTH - 1;
    localparam int LO_FINAL = (PIPE_DEPTH == 1) ? 0 : N_LVL;

    // One level: groups of three become sum/carry pairs, leftovers pass down unchanged.
    function automatic ops_t csa_level(input ops_t cur, input int n);
        ops_t            nxt;
        int              grp;
        logic [PP_W-1:0] a;
        logic [PP_W-1:0] b;
        logic [PP_W-1:0] c;
        nxt = '0;
        grp = n / 3;
        for (int g = 0; g < N_OP / 3; g++) begin
            if (g < grp) begin
                a = cur[IDX_W'(3 * g)];
                b = cur[IDX_W'(3 * g + 1)];
                c = cur[IDX_W'(3 * g + 2)];
                nxt[IDX_W'(2 * g)]     = a ^ b ^ c;
                nxt[IDX_W'(2 * g + 1)] = ((a & b) | (a & c) | (b & c)) << 1;
            end
        end
        for (int i = 0; i < N_OP; i++) begin
            if (i >= 3 * grp && i < n)
                nxt[IDX_W'(2 * grp + i - 3 * grp)] = cur[IDX_W'(i)];
        end
        return nxt;
    endfunction

    // Applies tree levels [lo, hi); n tracks the operand count entering each level.
    function automatic ops_t reduce_range(input ops_t ops, input int lo, input int hi);
        ops_t cur;
        int   n;
        cur = ops;
        n   = N_OP;
        for (int j = 0; j < N_LVL; j++) begin
            if (j >= lo && j < hi)
                cur = csa_level(cur, n);
            n = next_cnt(n);
        end
        return cur;
    endfunction

    function automatic logic [OUT_W-1:0] cpa(input ops_t ops);
        logic [PP_W-1:0] s;
        s = ops[0] + ops[1];
        return s[OUT_W-1:0];
    endfunction

    logic [PIPE_DEPTH:1] v_q;
    logic [TAG_W-1:0]    tag_q [1:PIPE_DEPTH];
    logic [OUT_W-1:0]    out_sum_q;
    logic                advance;
    ops_t                in_ops;
    ops_t                stage_in [1:PIPE_DEPTH];
    ops_t                final_ops;

    // Global stall: every stage moves together whenever the output slot is free or draining.
    assign advance       = ~v_q[PIPE_DEPTH] | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[PIPE_DEPTH];
    assign bus.out_sum   = out_sum_q;
    assign bus.out_tag   = tag_q[PIPE_DEPTH];

    assign in_ops      = {bus.sign_comp, bus.pp_flat};
    assign stage_in[1] = in_ops;

    for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_csa
        localparam int LO = ((k - 1) * N_LVL) / N_CSA_ST;
        localparam int HI = (k * N_LVL) / N_CSA_ST;
        ops_t ops_q;

        always_ff @(posedge clk) begin
            if (advance)
                ops_q <= reduce_range(stage_in[k], LO, HI);
        end

        assign stage_in[k+1] = ops_q;
    end

    assign final_ops = reduce_range(stage_in[PIPE_DEPTH], LO_FINAL, N_LVL);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            out_sum_q <= '0;
            for (int k = 1; k <= PIPE_DEPTH; k++)
                tag_q[k] <= '0;
        end else if (advance) begin
            v_q[1]    <= bus.in_valid;
            tag_q[1]  <= bus.in_tag;
            out_sum_q <= cpa(final_ops);
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                v_q[k]   <= v_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end
endmodule

// File: tb/tb_pp_reduce_pipe.sv
// Directed bench for pp_reduce_pipe: hand-computed vectors, stall/reset sequences and a
// short randomised traffic phase checked against an expected queue of {tag, sum}.
module tb_pp_reduce_pipe;
    localparam int N_PP       = 17;
    localparam int PP_W       = 68;
    localparam int OUT_W      = 64;
    localparam int PIPE_DEPTH = 3;
    localparam int TAG_W      = 4;
    localparam int SB_W       = TAG_W + OUT_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pp_reduce_if #(.N_PP(N_PP), .PP_W(PP_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

    pp_reduce_pipe #(
        .N_PP(N_PP), .PP_W(PP_W), .OUT_W(OUT_W), .PIPE_DEPTH(PIPE_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [PP_W-1:0]  pp [N_PP];
    logic [PP_W-1:0]  cur_sc;
    logic [TAG_W-1:0] cur_tag;
    logic [SB_W-1:0]  exp_q [$];

    task automatic check(input string name, input logic [SB_W-1:0] obs, input logic [SB_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_pp();
        for (int i = 0; i < N_PP; i++) pp[i] = '0;
    endtask

    task automatic present(input logic [PP_W-1:0] sc, input logic [TAG_W-1:0] tag);
        for (int i = 0; i < N_PP; i++) bus.pp_flat[i*PP_W +: PP_W] = pp[i];
        bus.sign_comp = sc;
        bus.in_tag    = tag;
        bus.in_valid  = 1'b1;
        cur_sc        = sc;
        cur_tag       = tag;
    endtask

    function automatic logic [OUT_W-1:0] model_sum();
        logic [PP_W-1:0] acc;
        acc = cur_sc;
        for (int i = 0; i < N_PP; i++) acc = acc + pp[i];
        return acc[OUT_W-1:0];
    endfunction

    function automatic logic [PP_W-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return r[PP_W-1:0];
        endcase
    endfunction

    // Single beat into an empty pipe with out_ready=1: result visible exactly three cycles later.
    task automatic single(input string name, input logic [PP_W-1:0] sc, input logic [TAG_W-1:0] tag,
                          input logic [OUT_W-1:0] exp_sum);
        present(sc, tag);
        check({name, "_in_ready"}, SB_W'(bus.in_ready), SB_W'(1));
        tick();
        bus.in_valid = 1'b0;
        check({name, "_ov_c1"}, SB_W'(bus.out_valid), SB_W'(0));
        tick();
        check({name, "_ov_c2"}, SB_W'(bus.out_valid), SB_W'(0));
        tick();
        check({name, "_ov_c3"}, SB_W'(bus.out_valid), SB_W'(1));
        check({name, "_sum"}, SB_W'(bus.out_sum), SB_W'(exp_sum));
        check({name, "_tag"}, SB_W'(bus.out_tag), SB_W'(tag));
        tick();
        check({name, "_ov_after"}, SB_W'(bus.out_valid), SB_W'(0));
    endtask

    // Samples the upcoming edge: pops on output transfer, pushes on input transfer.
    task automatic monitor(output logic accepted);
        #1;
        if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed output tag %0h sum %0h expected none", bus.out_tag, bus.out_sum);
            end
            if (exp_q.size() > 0) check("sb_out", {bus.out_tag, bus.out_sum}, exp_q.pop_front());
        end
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) exp_q.push_back({cur_tag, model_sum()});
    endtask

    initial begin
        logic hold;
        logic acc;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.pp_flat   = '0;
        bus.sign_comp = '0;
        bus.in_tag    = '0;
        cur_sc        = '0;
        cur_tag       = '0;
        clear_pp();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", SB_W'(bus.out_valid), SB_W'(0));
        check("rst_out_sum", SB_W'(bus.out_sum), SB_W'(0));
        check("rst_out_tag", SB_W'(bus.out_tag), SB_W'(0));
        check("rst_in_ready", SB_W'(bus.in_ready), SB_W'(1));
        tick();

        clear_pp();
        pp[0] = 68'd1;
        single("t1_one", '0, 4'd5, 64'd1);

        for (int i = 0; i < N_PP; i++) pp[i] = 68'hF_FFFF_FFFF_FFFF_FFFF;
        single("t2_wrap", 68'd17, 4'd2, 64'h0);

        clear_pp();
        pp[0] = 68'h8000_0000_0000_0000;
        pp[1] = 68'h8000_0000_0000_0000;
        single("t3_carry", '0, 4'd3, 64'h0);

        clear_pp();
        pp[0] = 68'hFFFF_FFFF_FFFF_FFFF;
        single("t3_sc_carry", 68'd1, 4'd4, 64'h0);

        for (int i = 0; i < N_PP; i++) pp[i] = PP_W'(i + 1);
        single("small_sum", 68'h100, 4'd9, 64'h199);

        clear_pp();
        pp[16] = 68'h8_0000_0000_0000_0003;
        single("high_bits", 68'd5, 4'hF, 64'h8);

        // Three beats back to back, consumer stalled for six cycles.
        bus.out_ready = 1'b0;
        clear_pp();
        pp[0] = 68'h100;
        pp[5] = 68'h23;
        present(68'd1, 4'd1);
        tick();
        clear_pp();
        pp[3] = 68'hABCD;
        present('0, 4'd2);
        tick();
        clear_pp();
        pp[16] = 68'hFFFF_FFFF_FFFF_FFFF;
        pp[2]  = 68'd2;
        present('0, 4'd3);
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("t4_hold_valid", SB_W'(bus.out_valid), SB_W'(1));
            check("t4_hold_in_ready", SB_W'(bus.in_ready), SB_W'(0));
            check("t4_hold_sum", SB_W'(bus.out_sum), SB_W'(64'h124));
            check("t4_hold_tag", SB_W'(bus.out_tag), SB_W'(1));
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("t4_in_ready_resume", SB_W'(bus.in_ready), SB_W'(1));
        check("t4_beat1", {bus.out_tag, bus.out_sum}, {4'd1, 64'h124});
        tick();
        check("t4_beat2_valid", SB_W'(bus.out_valid), SB_W'(1));
        check("t4_beat2", {bus.out_tag, bus.out_sum}, {4'd2, 64'hABCD});
        tick();
        check("t4_beat3_valid", SB_W'(bus.out_valid), SB_W'(1));
        check("t4_beat3", {bus.out_tag, bus.out_sum}, {4'd3, 64'h1});
        tick();
        check("t4_drained", SB_W'(bus.out_valid), SB_W'(0));

        // Two beats in flight, then reset coinciding with a third offered beat.
        clear_pp();
        pp[0] = 68'd7;
        present('0, 4'd6);
        tick();
        pp[0] = 68'd9;
        present('0, 4'd7);
        tick();
        rst   = 1'b1;
        pp[0] = 68'd11;
        present('0, 4'd8);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("t5_out_valid", SB_W'(bus.out_valid), SB_W'(0));
        check("t5_out_sum", SB_W'(bus.out_sum), SB_W'(0));
        check("t5_out_tag", SB_W'(bus.out_tag), SB_W'(0));
        check("t5_in_ready", SB_W'(bus.in_ready), SB_W'(1));
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t5_no_stale", SB_W'(bus.out_valid), SB_W'(0));
        end
        clear_pp();
        pp[8] = 68'h1234_5678;
        single("t5_recover", 68'h10, 4'hA, 64'h1234_5688);

        // Random valid/ready traffic; held beats keep their data until accepted.
        hold = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < N_PP; i++) pp[i] = rand_word();
                    present(rand_word(), TAG_W'($urandom_range(0, 15)));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 1) == 1);
            monitor(acc);
            hold = bus.in_valid && !acc;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 2 * PIPE_DEPTH + 4; cyc++) begin
            monitor(acc);
            tick();
        end
        check("sb_drain_empty", SB_W'(exp_q.size()), SB_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
